// File: rtl/mem_data_sub.sv
// mem_data_sub: CPU data memory behind the MEM stage.
// Byte/half/word loads and stores with sign or zero extension, one-cycle
// registered reads, and a clear sweep of every word after reset.
// Optional feature macro: MEM_DATA_ALIGN_CHECK_EN (misaligned/reserved
// access detection; faulty stores dropped, faulty loads return 0, err pulses).
module mem_data_sub #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W+1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              err,
    output logic              busy
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    // Only 32-bit words are supported
    generate
        if (DATA_W != WORD_W) begin : g_bad_data_w
            $error("mem_data_sub: DATA_W must be 32");
        end
    endgenerate

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              clr_we;
    logic              acc_en;

    logic [WORD_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] widx;
    logic [1:0]        lane;
    logic [3:0]        be;
    logic [31:0]       wshaped;
    logic [1:0]        sh;
    logic              fault;
    logic [31:0]       rword;
    logic [31:0]       shifted;
    logic [31:0]       ld_val;
    logic              st_en;
    logic              ld_en;

    assign widx = addr[ADDR_W+1:2];
    assign lane = addr[1:0];

    // State, sweep counter and busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (state_nxt == CLEAR);
        end
    end

    // Next state: sweep one word per cycle, then accept requests
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        acc_en    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we  = 1'b1;
                cnt_nxt = cnt + ADDR_W'(1);
                if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                acc_en = 1'b1;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Access decode: lane enables, replicated store data, load shift, fault
    always_comb begin
        be      = 4'b1111;
        wshaped = wdata;
        sh      = 2'd0;
        fault   = 1'b0;
        case (size)
            2'b00: begin
                be      = 4'b0001 << lane;
                wshaped = {4{wdata[7:0]}};
                sh      = lane;
            end
            2'b01: begin
                be      = addr[1] ? 4'b1100 : 4'b0011;
                wshaped = {2{wdata[15:0]}};
                sh      = {addr[1], 1'b0};
`ifdef MEM_DATA_ALIGN_CHECK_EN
                fault   = addr[0];
`endif
            end
            default: begin
`ifdef MEM_DATA_ALIGN_CHECK_EN
                fault   = (size == 2'b11) || (lane != 2'b00);
`endif
            end
        endcase
    end

    // Load extraction: move the selected lanes down, then extend
    always_comb begin
        rword   = mem[widx];
        shifted = rword >> {sh, 3'b000};
        case (size)
            2'b00:   ld_val = sign ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'd0, shifted[7:0]};
            2'b01:   ld_val = sign ? {{16{shifted[15]}}, shifted[15:0]}
                                   : {16'd0, shifted[15:0]};
            default: ld_val = shifted;
        endcase
    end

    assign st_en = acc_en && wr && !fault && !rst;
    assign ld_en = acc_en && rd;

    // Storage: sweep clears, otherwise per-lane store
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end else if (st_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wshaped[8*i +: 8];
                end
            end
        end
    end

    // Registered load result; rdata holds between loads
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= ld_en;
            if (ld_en) begin
                rdata <= fault ? 32'd0 : ld_val;
            end
        end
    end

`ifdef MEM_DATA_ALIGN_CHECK_EN
    // Error pulse one cycle after a faulty accepted request
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= acc_en && (rd || wr) && fault;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_data_sub.sv
// Self-checking bench for mem_data_sub (works with or without
// MEM_DATA_ALIGN_CHECK_EN defined).
module tb_mem_data_sub;

`ifdef MEM_DATA_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  addr;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sbq[$];

    mem_data_sub #(.ADDR_W(7), .DATA_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .rd     (rd),
        .wr     (wr),
        .size   (size),
        .sign   (sign),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request, held for one edge; load expectation goes to the scoreboard
    task automatic req(input logic r, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [8:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
        rd = r; wr = w; size = sz; sign = sg; addr = a; wdata = d;
        if (r) sbq.push_back(exp_rd);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        chk("err", {31'd0, err}, {31'd0, exp_err});
    endtask

    // Count cycles with busy high; optionally drive requests that must be ignored
    task automatic count_busy(input bit poke, input int poke_at, output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            rd = poke || (n == poke_at);
            wr = poke;
            @(negedge clk);
        end
        rd = 1'b0; wr = 1'b0;
    endtask

    // Scoreboard: every rvalid must match the oldest outstanding load
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rvalid", {31'd0, rvalid}, 32'd0);
            end else begin
                chk("rdata", rdata, sbq.pop_front());
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; rd = 1'b0; wr = 1'b0; size = 2'b10; sign = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);

        // Clear sweep with a load attempted mid-sweep
        rst = 1'b0;
        size = 2'b10; addr = 9'h1FC;
        count_busy(1'b0, 5, n);
        chk("sweep_cycles", 32'(n), 32'd128);
        req(1, 0, 2'b10, 0, 9'h1FC, 32'h0, 32'h0000_0000, 0);

        // Word round trip
        req(0, 1, 2'b10, 0, 9'd8, 32'h0008_77F8, 32'h0, 0);
        req(1, 0, 2'b10, 0, 9'd8, 32'h0, 32'h0008_77F8, 0);

        // Sub-word store and loads
        req(0, 1, 2'b00, 0, 9'd9, 32'h0000_0080, 32'h0, 0);
        req(1, 0, 2'b10, 0, 9'd8, 32'h0, 32'h0008_80F8, 0);
        req(1, 0, 2'b00, 1, 9'd9, 32'h0, 32'hFFFF_FF80, 0);
        req(1, 0, 2'b00, 0, 9'd9, 32'h0, 32'h0000_0080, 0);
        @(negedge clk);
        chk("hold_rvalid", {31'd0, rvalid}, 32'd0);
        chk("hold_rdata", rdata, 32'h0000_0080);

        // Read-before-write, then half/byte lanes
        req(1, 1, 2'b10, 0, 9'd8, 32'h1234_5678, 32'h0008_80F8, 0);
        req(1, 0, 2'b10, 0, 9'd8, 32'h0, 32'h1234_5678, 0);
        req(1, 0, 2'b01, 1, 9'd10, 32'h0, 32'h0000_1234, 0);
        req(1, 0, 2'b01, 1, 9'd8, 32'h0, 32'h0000_5678, 0);
        req(1, 0, 2'b00, 1, 9'd11, 32'h0, 32'h0000_0012, 0);
        req(0, 1, 2'b01, 0, 9'd10, 32'h0000_9ABC, 32'h0, 0);
        req(1, 0, 2'b01, 1, 9'd10, 32'h0, 32'hFFFF_9ABC, 0);
        req(1, 0, 2'b01, 0, 9'd10, 32'h0, 32'h0000_9ABC, 0);

        // Misaligned and reserved accesses
        req(0, 1, 2'b01, 0, 9'd3, 32'h0000_BEEF, 32'h0, ALIGN);
        req(1, 0, 2'b10, 0, 9'd0, 32'h0, ALIGN ? 32'h0 : 32'hBEEF_0000, 0);
        req(1, 0, 2'b10, 0, 9'd2, 32'h0, ALIGN ? 32'h0 : 32'hBEEF_0000, ALIGN);
        req(1, 0, 2'b11, 0, 9'd8, 32'h0, ALIGN ? 32'h0 : 32'h9ABC_5678, ALIGN);

        // Reset, then reset again mid-sweep; requests during the sweep are ignored
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        size = 2'b10; addr = 9'd8; wdata = 32'hFFFF_FFFF;
        count_busy(1'b1, 0, n);
        chk("resweep_cycles", 32'(n), 32'd128);
        req(1, 0, 2'b10, 0, 9'd8, 32'h0, 32'h0000_0000, 0);
        req(1, 0, 2'b10, 0, 9'h1FC, 32'h0, 32'h0000_0000, 0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
